resizer_controller: RTL

RESIZER_CONTROLLER -- requirements
Module: resizer_controller

---
 rtl/resizer_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/resizer_controller.sv
// rtl/resizer_controller.sv - camera-to-resizer frame controller with output buffer write sequencing
// Arms on enable, streams one frame into the resizer, holds the buffered result until the consumer acks.
module resizer_controller #(
    parameter int DATA_WIDTH   = 24,
    parameter int INPUT_WIDTH  = 640,
    parameter int INPUT_HEIGHT = 480,
    parameter int OUT_DIM      = 224,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  camFrameStart,
    input  logic [DATA_WIDTH-1:0] camPixelData,
    input  logic                  camPixelValid,
    output logic                  rszClear,
    output logic                  rszStartNewImage,
    output logic [DATA_WIDTH-1:0] rszPixelData,
    output logic                  rszPixelValid,
    input  logic                  rszOutValid,
    input  logic                  rszEndOfImage,
    output logic                  bufWriteEnable,
    output logic [ADDR_WIDTH-1:0] bufWriteAddr,
    output logic                  frameReady,
    input  logic                  frameAck,
    output logic                  busy,
    output logic [7:0]            framesDropped,
    output logic                  error
);

    localparam logic [19:0]           IN_TOTAL  = 20'(INPUT_WIDTH * INPUT_HEIGHT);
    localparam logic [16:0]           OUT_TOTAL = 17'(OUT_DIM * OUT_DIM);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(OUT_DIM * OUT_DIM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, HOLD} state_t;

    state_t                state, stateNext;
    logic [19:0]           inCount, inCountNext;
    logic [ADDR_WIDTH-1:0] writeAddr, writeAddrNext;
    logic [16:0]           writeCount, writeCountNext;
    logic                  eoiSeen, eoiNext;
    logic                  errorFlag, errorNext;
    logic [7:0]            dropCount, dropNext, dropInc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            inCount    <= '0;
            writeAddr  <= '0;
            writeCount <= '0;
            eoiSeen    <= 1'b0;
            errorFlag  <= 1'b0;
            dropCount  <= '0;
        end else begin
            state      <= stateNext;
            inCount    <= inCountNext;
            writeAddr  <= writeAddrNext;
            writeCount <= writeCountNext;
            eoiSeen    <= eoiNext;
            errorFlag  <= errorNext;
            dropCount  <= dropNext;
        end
    end

    always_comb begin
        stateNext        = state;
        inCountNext      = inCount;
        writeAddrNext    = writeAddr;
        writeCountNext   = writeCount;
        eoiNext          = eoiSeen | rszEndOfImage;
        errorNext        = errorFlag;
        dropNext         = dropCount;
        dropInc          = (dropCount == 8'hFF) ? dropCount : dropCount + 8'd1;
        rszClear         = 1'b0;
        rszStartNewImage = 1'b0;
        rszPixelValid    = 1'b0;
        bufWriteEnable   = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext = WAIT_SOF;
                    rszClear  = 1'b1;
                end
            end
            WAIT_SOF: begin
                rszStartNewImage = camFrameStart;
                if (camFrameStart) begin
                    stateNext      = STREAM;
                    inCountNext    = '0;
                    writeAddrNext  = '0;
                    writeCountNext = '0;
                    eoiNext        = 1'b0;
                end
            end
            STREAM: begin
                rszPixelValid  = camPixelValid && (inCount != IN_TOTAL);
                bufWriteEnable = rszOutValid;
                if (camFrameStart) begin
                    // A new frame overtook the current one: abandon it and re-arm.
                    stateNext      = WAIT_SOF;
                    rszClear       = 1'b1;
                    errorNext      = 1'b1;
                    dropNext       = dropInc;
                    inCountNext    = '0;
                    writeAddrNext  = '0;
                    writeCountNext = '0;
                    eoiNext        = 1'b0;
                end else begin
                    if (rszPixelValid)
                        inCountNext = inCount + 20'd1;
                    if (rszOutValid) begin
                        writeCountNext = (writeCount == 17'h1FFFF) ? writeCount : writeCount + 17'd1;
                        writeAddrNext  = (writeAddr == ADDR_LAST) ? writeAddr : writeAddr + 1'b1;
                    end
                    // Next-state values let the last pixel and EOI close the frame in their own cycle.
                    if ((inCountNext == IN_TOTAL) && eoiNext) begin
                        stateNext = HOLD;
                        if (writeCountNext != OUT_TOTAL)
                            errorNext = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (camFrameStart)
                    dropNext = dropInc;
                if (frameAck) begin
                    if (enable) begin
                        stateNext = WAIT_SOF;
                        rszClear  = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign rszPixelData  = camPixelData;
    assign bufWriteAddr  = writeAddr;
    assign frameReady    = (state == HOLD);
    assign busy          = (state != IDLE);
    assign framesDropped = dropCount;
    assign error         = errorFlag;

endmodule
